// File: rtl/expr_pkg.sv
// Shared constants for the expression generator/checker pair: ASCII codes and FSM state encoding.
package expr_pkg;

  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_PLUS = 8'h2B;
  localparam logic [7:0] CH_MUL  = 8'h2A;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DIG  = 2'd1,
    OP   = 2'd2
  } state_t;

endpackage

// File: rtl/expr_gen_if.sv
// Character stream from the generator to an expression sink (e.g. the checker FSM).
interface expr_gen_if;
  logic [7:0] out;
  logic       out_valid;
  logic       out_ready;
  logic       sof;
  logic       eof;

  modport master (output out, output out_valid, output sof, output eof, input out_ready);
  modport slave  (input out, input out_valid, input sof, input eof, output out_ready);
endinterface

// File: rtl/expr_gen.sv
// Streams "digit (op digit)*" one ASCII character per accepted beat from operands latched at start.
module expr_gen
  import expr_pkg::*;
#(
  parameter int unsigned MAX_TERMS = 8,
  parameter int unsigned LEN_W     = 4
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   start,
  input  logic [LEN_W-1:0]       len,
  input  logic [4*MAX_TERMS-1:0] digits,
  input  logic [MAX_TERMS-2:0]   ops,
  expr_gen_if.master             tx,
  output logic                   busy,
  output logic                   done,
  output logic                   err
);

  localparam int unsigned IDX_W = (MAX_TERMS > 2) ? $clog2(MAX_TERMS) : 1;
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_TERMS);

  state_t                 state_q, state_n;
  logic [IDX_W-1:0]       idx_q, idx_n;
  logic [LEN_W-1:0]       len_q, len_n;
  logic [4*MAX_TERMS-1:0] dig_q, dig_n;
  logic [MAX_TERMS-2:0]   ops_q, ops_n;

  logic       beat, req_ok, bad_digit, done_n, err_n;
  logic [3:0] operand;
  logic       opsel;
  logic [7:0] out_n;
  logic       sof_n, eof_n;

  // Outputs are computed from the *next* state so they can be registered
  // without adding a cycle of latency or a path from out_ready.
  always_comb begin
    state_n   = state_q;
    idx_n     = idx_q;
    len_n     = len_q;
    dig_n     = dig_q;
    ops_n     = ops_q;
    done_n    = 1'b0;
    err_n     = 1'b0;
    beat      = tx.out_valid & tx.out_ready;
    bad_digit = 1'b0;

    for (int unsigned k = 0; k < MAX_TERMS; k++) begin
      if ((LEN_W'(k) < len) && (digits[4*k +: 4] > 4'd9)) bad_digit = 1'b1;
    end
    req_ok = (len != '0) && (len <= MAX_LEN) && !bad_digit;

    case (state_q)
      IDLE: begin
        if (start) begin
          if (req_ok) begin
            state_n = DIG;
            idx_n   = '0;
            len_n   = len;
            dig_n   = digits;
            ops_n   = ops;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      DIG: begin
        if (beat) begin
          if (tx.eof) begin
            state_n = IDLE;
            done_n  = 1'b1;
          end else begin
            state_n = OP;
          end
        end
      end
      OP: begin
        if (beat) begin
          idx_n   = idx_q + 1'b1;
          state_n = DIG;
        end
      end
      default: state_n = IDLE;
    endcase

    operand = '0;
    for (int unsigned k = 0; k < MAX_TERMS; k++) begin
      if (idx_n == IDX_W'(k)) operand = dig_n[4*k +: 4];
    end
    opsel = 1'b0;
    for (int unsigned k = 0; k < MAX_TERMS - 1; k++) begin
      if (idx_n == IDX_W'(k)) opsel = ops_n[k];
    end

    out_n = '0;
    sof_n = 1'b0;
    eof_n = 1'b0;
    case (state_n)
      DIG: begin
        out_n = CH_0 + {4'h0, operand};
        sof_n = (idx_n == '0);
        eof_n = (LEN_W'(idx_n) == len_n - 1'b1);
      end
      OP:      out_n = opsel ? CH_MUL : CH_PLUS;
      default: out_n = '0;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      len_q        <= '0;
      dig_q        <= '0;
      ops_q        <= '0;
      tx.out       <= '0;
      tx.out_valid <= 1'b0;
      tx.sof       <= 1'b0;
      tx.eof       <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      state_q      <= state_n;
      idx_q        <= idx_n;
      len_q        <= len_n;
      dig_q        <= dig_n;
      ops_q        <= ops_n;
      tx.out       <= out_n;
      tx.out_valid <= (state_n != IDLE);
      tx.sof       <= sof_n;
      tx.eof       <= eof_n;
      busy         <= (state_n != IDLE);
      done         <= done_n;
      err          <= err_n;
    end
  end

endmodule

// File: tb/tb_expr_gen.sv
// Directed bench for expr_gen: frames, backpressure, rejects, abort and back-to-back starts.
module tb_expr_gen;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  len = '0;
  logic [31:0] digits = '0;
  logic [6:0]  ops = '0;
  logic        busy, done, err;

  int checks = 0;
  int passes = 0;

  expr_gen_if bus();

  expr_gen #(.MAX_TERMS(8), .LEN_W(4)) dut (
    .clk    (clk),
    .clr    (clr),
    .start  (start),
    .len    (len),
    .digits (digits),
    .ops    (ops),
    .tx     (bus.master),
    .busy   (busy),
    .done   (done),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Grammar acceptor standing in for the downstream checker FSM.
  function automatic bit accepts(input string s);
    if (s.len() % 2 == 0) return 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      if (i % 2 == 0) begin
        if (s[i] < 8'h30 || s[i] > 8'h39) return 1'b0;
      end else begin
        if (s[i] != 8'h2B && s[i] != 8'h2A) return 1'b0;
      end
    end
    return 1'b1;
  endfunction

  // Receives one frame; ready drops for stall_cyc cycles on character stall_idx.
  // Returns one sample after the eof beat (where done should be high).
  task automatic collect(input int stall_idx, input int stall_cyc, output string s,
                         output int cyc, output bit sof_ok, output bit stable, output bit got_eof);
    int n = 0;
    int stalled = 0;
    logic [7:0] held = '0;
    s = ""; cyc = 0; sof_ok = 1'b1; stable = 1'b1; got_eof = 1'b0;
    for (int t = 0; t < 200; t++) begin
      if (bus.out_valid) begin
        if (n == stall_idx && stalled < stall_cyc) begin
          if (stalled > 0 && bus.out !== held) stable = 1'b0;
          held = bus.out;
          stalled++;
          bus.out_ready = 1'b0;
        end else begin
          if (stalled > 0 && n == stall_idx && bus.out !== held) stable = 1'b0;
          bus.out_ready = 1'b1;
          s = $sformatf("%s%c", s, bus.out);
          if (bus.sof !== (n == 0)) sof_ok = 1'b0;
          n++;
          if (bus.eof) begin
            cyc = t + 1;
            got_eof = 1'b1;
            tick();
            return;
          end
        end
      end else begin
        bus.out_ready = 1'b1;
      end
      tick();
    end
  endtask

  task automatic launch(input logic [3:0] l, input logic [31:0] d, input logic [6:0] o);
    len = l; digits = d; ops = o; start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({bus.out, bus.out_valid, bus.sof, bus.eof, busy, done, err} !== 14'h0) begin
      $display("FAIL reset_outputs: got %h required 0",
               {bus.out, bus.out_valid, bus.sof, bus.eof, busy, done, err});
    end else passes++;
    clr = 1'b0;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_idle_valid: got %b required 0", bus.out_valid);
    else passes++;
  endtask

  task automatic test_basic();
    string s; int cyc; bit sof_ok, stable, got_eof;
    launch(4'd3, 32'h0000_0927, 7'b0000010);
    collect(-1, 0, s, cyc, sof_ok, stable, got_eof);
    checks++;
    if (s != "7+2*9") $display("FAIL basic_stream: got %s required 7+2*9", s); else passes++;
    checks++;
    if (cyc != 5 || !got_eof) $display("FAIL basic_cycles: got %0d required 5", cyc); else passes++;
    checks++;
    if (!sof_ok) $display("FAIL basic_sof: got misplaced sof required sof on first char only"); else passes++;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL basic_done: got done=%b busy=%b required done=1 busy=0", done, busy);
    else passes++;
    checks++;
    if (!accepts(s)) $display("FAIL basic_checker: got reject required accept for %s", s); else passes++;
    tick();
    checks++;
    if (done !== 1'b0) $display("FAIL basic_done_pulse: got %b required 0", done); else passes++;
  endtask

  task automatic test_backpressure();
    string s; int cyc; bit sof_ok, stable, got_eof;
    launch(4'd3, 32'h0000_0927, 7'b0000010);
    collect(1, 3, s, cyc, sof_ok, stable, got_eof);
    checks++;
    if (s != "7+2*9") $display("FAIL bp_stream: got %s required 7+2*9", s); else passes++;
    checks++;
    if (cyc != 8 || !got_eof) $display("FAIL bp_cycles: got %0d required 8", cyc); else passes++;
    checks++;
    if (!stable) $display("FAIL bp_hold: got changing out required stable while stalled"); else passes++;
    tick();
  endtask

  task automatic test_single();
    string s; int cyc; bit sof_ok, stable, got_eof;
    launch(4'd1, 32'h0000_0000, 7'b0);
    checks++;
    if (bus.sof !== 1'b1 || bus.eof !== 1'b1 || busy !== 1'b1)
      $display("FAIL single_flags: got sof=%b eof=%b busy=%b required 1 1 1", bus.sof, bus.eof, busy);
    else passes++;
    collect(-1, 0, s, cyc, sof_ok, stable, got_eof);
    checks++;
    if (s != "0" || cyc != 1) $display("FAIL single_stream: got %s in %0d cycles required 0 in 1", s, cyc);
    else passes++;
    checks++;
    if (done !== 1'b1 || busy !== 1'b0)
      $display("FAIL single_done: got done=%b busy=%b required done=1 busy=0", done, busy);
    else passes++;
    tick();
  endtask

  task automatic test_reject();
    launch(4'd0, 32'h0000_0012, 7'b0);
    checks++;
    if (err !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL reject_len0: got err=%b valid=%b busy=%b required 1 0 0", err, bus.out_valid, busy);
    else passes++;
    tick();
    checks++;
    if (err !== 1'b0) $display("FAIL reject_pulse: got %b required 0", err); else passes++;
    launch(4'd2, 32'h0000_00A3, 7'b0);
    checks++;
    if (err !== 1'b1 || bus.out_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL reject_bcd: got err=%b valid=%b busy=%b required 1 0 0", err, bus.out_valid, busy);
    else passes++;
    launch(4'd9, 32'h1111_1111, 7'b0);
    checks++;
    if (err !== 1'b1 || bus.out_valid !== 1'b0)
      $display("FAIL reject_len9: got err=%b valid=%b required 1 0", err, bus.out_valid);
    else passes++;
    tick();
  endtask

  task automatic test_abort();
    string s; int cyc; bit sof_ok, stable, got_eof;
    launch(4'd3, 32'h0000_0927, 7'b0000010);
    len = 4'd1; digits = 32'h5; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (bus.out !== 8'h2B || err !== 1'b0)
      $display("FAIL abort_ignore_start: got out=%h err=%b required 2b 0", bus.out, err);
    else passes++;
    tick();
    clr = 1'b1;
    #1;
    checks++;
    if ({bus.out, bus.out_valid, bus.sof, bus.eof, busy, done, err} !== 14'h0)
      $display("FAIL abort_clear: got %h required 0",
               {bus.out, bus.out_valid, bus.sof, bus.eof, busy, done, err});
    else passes++;
    #2;
    clr = 1'b0;
    tick();
    launch(4'd2, 32'h0000_0043, 7'b0000001);
    collect(-1, 0, s, cyc, sof_ok, stable, got_eof);
    checks++;
    if (s != "3*4" || !sof_ok || cyc != 3)
      $display("FAIL abort_fresh: got %s sof_ok=%b cyc=%0d required 3*4 1 3", s, sof_ok, cyc);
    else passes++;
    tick();
  endtask

  task automatic test_back_to_back();
    string s; int cyc; bit sof_ok, stable, got_eof;
    launch(4'd2, 32'h0000_0021, 7'b0);
    collect(-1, 0, s, cyc, sof_ok, stable, got_eof);
    checks++;
    if (s != "1+2" || done !== 1'b1) $display("FAIL b2b_first: got %s done=%b required 1+2 1", s, done);
    else passes++;
    launch(4'd8, 32'h8765_4321, 7'b1010101);
    collect(-1, 0, s, cyc, sof_ok, stable, got_eof);
    checks++;
    if (s != "1*2+3*4+5*6+7*8") $display("FAIL b2b_stream: got %s required 1*2+3*4+5*6+7*8", s);
    else passes++;
    checks++;
    if (cyc != 15 || !sof_ok) $display("FAIL b2b_cycles: got %0d sof_ok=%b required 15 1", cyc, sof_ok);
    else passes++;
    checks++;
    if (!accepts(s)) $display("FAIL b2b_checker: got reject required accept for %s", s); else passes++;
    tick();
  endtask

  initial begin
    bus.out_ready = 1'b1;
    #2;
    test_reset();
    test_basic();
    test_backpressure();
    test_single();
    test_reject();
    test_abort();
    test_back_to_back();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
